// File: rtl/router_fsm_nch.sv
// rtl/router_fsm_nch.sv - 1xN router control FSM (optional WAIT_TILL_EMPTY watchdog: ROUTER_WAIT_TIMEOUT_EN)
module router_fsm_nch #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_reset,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              write_enb_reg,
  output logic              detect_add,
  output logic              ld_state,
  output logic              laf_state,
  output logic              lfd_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              busy,
  output logic [NUM_CH-1:0] addr_sel,
  output logic              drop_pkt
);

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    FIFO_FULL_STATE    = 4'd3,
    LOAD_AFTER_FULL    = 4'd4,
    LOAD_PARITY        = 4'd5,
    CHECK_PARITY_ERROR = 4'd6,
    WAIT_TILL_EMPTY    = 4'd7,
    DROP_PACKET        = 4'd8
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [NUM_CH-1:0] hdr_sel;
  logic              hdr_ok;
  logic              hdr_empty;
  logic              sel_empty;
  logic              sel_soft_reset;

`ifdef ROUTER_WAIT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
`endif

  // Decode the header address into a one-hot channel and check it is in range
  always_comb begin
    hdr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(data_in) == i) hdr_sel[i] = 1'b1;
    end
    hdr_ok    = int'(data_in) < NUM_CH;
    hdr_empty = |(hdr_sel & fifo_empty);
  end

  assign sel_empty      = |(addr_sel & fifo_empty);
  assign sel_soft_reset = |(soft_reset & addr_sel);

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= DECODE_ADDRESS;
    else         state <= state_next;
  end

  // Next-state logic; a soft reset on the selected channel overrides everything
  always_comb begin
    state_next = state;
    case (state)
      DECODE_ADDRESS: begin
        if (pkt_valid) begin
          if (!hdr_ok)        state_next = DROP_PACKET;
          else if (hdr_empty) state_next = LOAD_FIRST_DATA;
          else                state_next = WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_next = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_next = FIFO_FULL_STATE;
        else if (!pkt_valid) state_next = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) state_next = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_next = DECODE_ADDRESS;
        else if (low_pkt_valid) state_next = LOAD_PARITY;
        else                    state_next = LOAD_DATA;
      end
      LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        if (fifo_full) state_next = FIFO_FULL_STATE;
        else           state_next = DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        if (sel_empty) state_next = LOAD_FIRST_DATA;
`ifdef ROUTER_WAIT_TIMEOUT_EN
        else if (wait_cnt == CW'(TIMEOUT - 1)) state_next = DROP_PACKET;
`endif
      end
      DROP_PACKET: begin
        if (!pkt_valid) state_next = DECODE_ADDRESS;
      end
      default: state_next = DECODE_ADDRESS;
    endcase
    if (sel_soft_reset && state != DECODE_ADDRESS && state != DROP_PACKET)
      state_next = DECODE_ADDRESS;
  end

  // Channel select: latched on a valid header, cleared when a packet is dropped
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                                         addr_sel <= '0;
    else if (state_next == DROP_PACKET)                  addr_sel <= '0;
    else if (state == DECODE_ADDRESS && pkt_valid && hdr_ok) addr_sel <= hdr_sel;
  end

`ifdef ROUTER_WAIT_TIMEOUT_EN
  // Watchdog: counts cycles spent in WAIT_TILL_EMPTY, restarting on each entry
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      wait_cnt <= '0;
    else if (state != WAIT_TILL_EMPTY && state_next == WAIT_TILL_EMPTY)
      wait_cnt <= '0;
    else if (state == WAIT_TILL_EMPTY && wait_cnt != CW'(TIMEOUT))
      wait_cnt <= wait_cnt + 1'b1;
  end
`endif

  // Moore output decode
  always_comb begin
    write_enb_reg = 1'b0;
    detect_add    = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    lfd_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b0;
    drop_pkt      = 1'b0;
    case (state)
      DECODE_ADDRESS:     detect_add = 1'b1;
      LOAD_FIRST_DATA:    begin lfd_state = 1'b1; busy = 1'b1; end
      LOAD_DATA:          begin ld_state = 1'b1; write_enb_reg = 1'b1; end
      FIFO_FULL_STATE:    begin full_state = 1'b1; busy = 1'b1; end
      LOAD_AFTER_FULL:    begin laf_state = 1'b1; busy = 1'b1; write_enb_reg = 1'b1; end
      LOAD_PARITY:        begin busy = 1'b1; write_enb_reg = 1'b1; end
      CHECK_PARITY_ERROR: begin rst_int_reg = 1'b1; busy = 1'b1; end
      WAIT_TILL_EMPTY:    busy = 1'b1;
      DROP_PACKET:        drop_pkt = 1'b1;
      default:            detect_add = 1'b1;
    endcase
  end

endmodule
